instr_fetch_unit: RTL and testbench

- Program-sequencing stage directly upstream of the opcode decoder.
- Holds the program counter and fetches 13-bit instruction words from the instruction ROM over a req/ack handshake.
- Splits each word into a 5-bit opcode, which drives the decoder's address input, and an 8-bit literal for the datapath B-mux.
- Emits a one-cycle instr_valid strobe that qualifies the decoder's register-load outputs; handles jumps, halt and illegal opcodes.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pc_reg.sv | 23 ++
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: field widths, instruction-word layout
// and the fetch state encoding.
package cpu_pkg;

    localparam int OP_W    = 5;
    localparam int LIT_W   = 8;
    localparam int INSTR_W = OP_W + LIT_W;

    localparam logic [OP_W-1:0] LAST_OP = 5'd24;

    // Opcode occupies the MSBs of the ROM word, literal the LSBs.
    localparam int OP_MSB  = INSTR_W - 1;
    localparam int OP_LSB  = LIT_W;
    localparam int LIT_MSB = LIT_W - 1;
    localparam int LIT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetchState_t;

    function automatic logic isIllegalOp(input logic [OP_W-1:0] op);
        return op > LAST_OP;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with jump load and increment, wrapping modulo 2^W.
module pc_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         loadEn,
    input  logic         incEn,
    input  logic [W-1:0] loadVal,
    output logic [W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (loadEn) begin
            pc <= loadVal;
        end else if (incEn) begin
            pc <= pc + W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks the PC, fetches ROM words over req/ack and presents
// opcode/literal with a one-cycle instr_valid strobe.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// FETCH | rom_req held with rom_addr=pc until rom_ack
// EXEC  | one cycle, instr_valid high, pc advances or jumps
// HALT  | stopped by halt request or illegal opcode, waiting for start
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    output logic [PC_W-1:0]    rom_addr,
    output logic               rom_req,
    input  logic               rom_ack,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_addr,
    output logic [OP_W-1:0]    opcode,
    output logic [LIT_W-1:0]   literal,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               illegal
);

    fetchState_t state;
    logic        haltPend;
    logic        inExec;

    assign inExec   = (state == EXEC);
    assign busy     = (state == FETCH) | (state == EXEC);
    assign rom_addr = pc;

    pc_reg #(.W(PC_W)) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .loadEn  (inExec & jump_en),
        .incEn   (inExec & ~jump_en),
        .loadVal (jump_addr),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opcode      <= '0;
            literal     <= '0;
            rom_req     <= 1'b0;
            instr_valid <= 1'b0;
            illegal     <= 1'b0;
            haltPend    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        rom_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (halt_req) haltPend <= 1'b1;
                    if (rom_ack && rom_req) begin
                        opcode  <= rom_data[OP_MSB:OP_LSB];
                        literal <= rom_data[LIT_MSB:LIT_LSB];
                        rom_req <= 1'b0;
                        if (isIllegalOp(rom_data[OP_MSB:OP_LSB])) begin
                            illegal <= 1'b1;
                            state   <= HALT;
                        end else begin
                            instr_valid <= 1'b1;
                            state       <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (halt_req || haltPend) begin
                        state <= HALT;
                    end else begin
                        state   <= FETCH;
                        rom_req <= 1'b1;
                    end
                end
                HALT: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_req  <= 1'b1;
                        illegal  <= 1'b0;
                        haltPend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of instruction steps against a
// behavioural ROM with programmable ack delay, plus illegal/halt/reset sequences.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               halt_req = 1'b0;
    logic [7:0]         rom_addr;
    logic               rom_req;
    logic               rom_ack;
    logic [INSTR_W-1:0] rom_data;
    logic               jump_en = 1'b0;
    logic [7:0]         jump_addr = 8'h00;
    logic [OP_W-1:0]    opcode;
    logic [LIT_W-1:0]   literal;
    logic               instr_valid;
    logic [7:0]         pc;
    logic               busy;
    logic               illegal;

    int nChecks = 0;
    int nFails  = 0;

    logic [INSTR_W-1:0] romMem [256];
    int ackDelay  = 0;
    int reqCycles = 0;

    typedef struct {
        logic [7:0] pcExp;
        logic [4:0] opExp;
        logic [7:0] litExp;
        logic       jumpEn;
        logic [7:0] jumpAddr;
        logic       haltReq;
        int         delay;
        logic [7:0] pcNext;
    } step_t;

    step_t tbl [12];

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .rom_addr    (rom_addr),
        .rom_req     (rom_req),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .opcode      (opcode),
        .literal     (literal),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .illegal     (illegal)
    );

    // ROM answers once rom_req has been held for ackDelay full cycles.
    assign rom_ack  = rom_req && (reqCycles >= ackDelay);
    assign rom_data = romMem[rom_addr];

    always @(posedge clk) begin
        if (rom_req && !rom_ack) reqCycles <= reqCycles + 1;
        else                     reqCycles <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic runStep(input int i);
        step_t s;
        logic  seen;
        logic  stableOk;
        int    reqCnt;
        s         = tbl[i];
        ackDelay  = s.delay;
        jump_en   = s.jumpEn;
        jump_addr = s.jumpAddr;
        halt_req  = s.haltReq;
        seen      = 1'b0;
        stableOk  = 1'b1;
        reqCnt    = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (rom_req) begin
                reqCnt++;
                if (rom_addr !== s.pcExp) stableOk = 1'b0;
            end
            if (instr_valid) seen = 1'b1;
        end
        check($sformatf("step%0d_valid_seen", i), 32'(seen), 32'd1);
        check($sformatf("step%0d_req_cycles", i), reqCnt, s.delay + 1);
        check($sformatf("step%0d_addr_stable", i), 32'(stableOk), 32'd1);
        check($sformatf("step%0d_opcode", i), 32'(opcode), 32'(s.opExp));
        check($sformatf("step%0d_literal", i), 32'(literal), 32'(s.litExp));
        check($sformatf("step%0d_pc", i), 32'(pc), 32'(s.pcExp));
        check($sformatf("step%0d_busy", i), 32'(busy), 32'd1);
        @(posedge clk); #1;
        check($sformatf("step%0d_valid_single", i), 32'(instr_valid), 32'd0);
        check($sformatf("step%0d_pc_next", i), 32'(pc), 32'(s.pcNext));
        if (s.haltReq) begin
            check($sformatf("step%0d_halt_busy", i), 32'(busy), 32'd0);
            check($sformatf("step%0d_halt_req", i), 32'(rom_req), 32'd0);
        end else begin
            check($sformatf("step%0d_next_req", i), 32'(rom_req), 32'd1);
            check($sformatf("step%0d_next_addr", i), 32'(rom_addr), 32'(s.pcNext));
        end
        jump_en  = 1'b0;
        halt_req = 1'b0;
    endtask

    initial begin
        logic validSeen;
        logic gotIllegal;

        for (int a = 0; a < 256; a++) romMem[a] = '0;
        romMem[8'h00] = {5'd0, 8'h11};
        romMem[8'h01] = {5'd1, 8'h22};
        romMem[8'h02] = {5'd2, 8'h33};
        romMem[8'h03] = {5'd3, 8'h44};
        romMem[8'h04] = {5'd4, 8'h55};
        romMem[8'h05] = {5'd5, 8'h66};
        romMem[8'h40] = {5'd6, 8'h77};
        romMem[8'h06] = {5'd7, 8'h88};
        romMem[8'h07] = {5'd25, 8'h99};
        romMem[8'hFF] = {5'd9, 8'hCD};
        romMem[8'h20] = {5'd24, 8'hEE};
        romMem[8'h21] = {5'd1, 8'h01};

        //            pc     op     lit    jmp   jaddr  halt  dly  next
        tbl[0]  = '{8'h00, 5'd0,  8'h11, 1'b0, 8'h00, 1'b0, 0, 8'h01};
        tbl[1]  = '{8'h01, 5'd1,  8'h22, 1'b0, 8'h00, 1'b0, 3, 8'h02};
        tbl[2]  = '{8'h02, 5'd2,  8'h33, 1'b0, 8'h00, 1'b0, 0, 8'h03};
        tbl[3]  = '{8'h03, 5'd3,  8'h44, 1'b0, 8'h00, 1'b0, 0, 8'h04};
        tbl[4]  = '{8'h04, 5'd4,  8'h55, 1'b0, 8'h00, 1'b0, 1, 8'h05};
        tbl[5]  = '{8'h05, 5'd5,  8'h66, 1'b1, 8'h40, 1'b0, 0, 8'h40};
        tbl[6]  = '{8'h40, 5'd6,  8'h77, 1'b1, 8'h06, 1'b0, 0, 8'h06};
        tbl[7]  = '{8'h06, 5'd7,  8'h88, 1'b0, 8'h00, 1'b0, 0, 8'h07};
        tbl[8]  = '{8'h07, 5'd8,  8'hAB, 1'b1, 8'hFF, 1'b0, 0, 8'hFF};
        tbl[9]  = '{8'hFF, 5'd9,  8'hCD, 1'b0, 8'h00, 1'b0, 0, 8'h00};
        tbl[10] = '{8'h00, 5'd0,  8'h11, 1'b1, 8'h20, 1'b1, 2, 8'h20};
        tbl[11] = '{8'h20, 5'd24, 8'hEE, 1'b0, 8'h00, 1'b0, 0, 8'h21};

        #1;
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_literal", 32'(literal), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_req", 32'(rom_req), 32'd0);

        pulseStart();
        check("start_req", 32'(rom_req), 32'd1);
        for (int i = 0; i <= 7; i++) runStep(i);

        // Illegal opcode at pc 7: halt without a strobe, jump_en ignored in HALT.
        validSeen  = 1'b0;
        gotIllegal = 1'b0;
        for (int c = 0; c < 10 && !gotIllegal; c++) begin
            @(negedge clk);
            if (instr_valid) validSeen = 1'b1;
            if (illegal) gotIllegal = 1'b1;
        end
        check("ill_flag", 32'(gotIllegal), 32'd1);
        check("ill_no_valid", 32'(validSeen), 32'd0);
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_req", 32'(rom_req), 32'd0);
        check("ill_pc", 32'(pc), 32'h07);
        check("ill_opcode", 32'(opcode), 32'd25);
        @(posedge clk); #1;
        jump_en   = 1'b1;
        jump_addr = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        jump_en = 1'b0;
        check("ill_hold_pc", 32'(pc), 32'h07);
        check("ill_hold_flag", 32'(illegal), 32'd1);
        check("ill_hold_busy", 32'(busy), 32'd0);
        romMem[8'h07] = {5'd8, 8'hAB};
        pulseStart();
        check("resume_illegal_clr", 32'(illegal), 32'd0);
        check("resume_req", 32'(rom_req), 32'd1);
        check("resume_addr", 32'(rom_addr), 32'h07);

        for (int i = 8; i <= 10; i++) runStep(i);

        // Halted after jump+halt in the same EXEC; resume at the jump target.
        repeat (3) @(posedge clk);
        #1;
        check("halt_hold_busy", 32'(busy), 32'd0);
        check("halt_hold_pc", 32'(pc), 32'h20);
        pulseStart();
        check("halt_resume_req", 32'(rom_req), 32'd1);
        check("halt_resume_addr", 32'(rom_addr), 32'h20);
        runStep(11);

        // Asynchronous reset in the middle of a stalled fetch.
        ackDelay = 10;
        @(posedge clk); #3;
        check("pre_rst_req", 32'(rom_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(rom_req), 32'd0);
        check("async_rst_pc", 32'(pc), 32'd0);
        check("async_rst_opcode", 32'(opcode), 32'd0);
        check("async_rst_literal", 32'(literal), 32'd0);
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_req", 32'(rom_req), 32'd0);
        check("post_rst_pc", 32'(pc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
